// File: rtl/if_fetch_unit.sv
// -----------------------------------------------------------------------------
// if_fetch_unit
//   IF stage of the 5-stage MIPS pipeline. Owns the PC, issues one word fetch
//   at a time to instruction memory, and captures returned words in the IF/ID
//   register. A 1-entry skid buffer absorbs the word that lands while ID is
//   stalled. A redirect from ID (no delay slots) squashes wrong-path fetches;
//   a request already on the bus is drained in KILL with its address frozen.
//
// Ports
//   clk           in   1   rising-edge clock
//   rst_n         in   1   asynchronous active-low reset
//   stall         in   1   ID holds its instruction this cycle
//   redirect      in   1   ID: taken branch / jump / jr, load redirect_npc
//   redirect_npc  in  30   next-PC word address [31:2]
//   imem_req      out  1   fetch request valid
//   imem_addr     out 30   fetch word address [31:2]
//   imem_ready    in   1   imem_rdata valid; completes the request
//   imem_rdata    in  32   instruction word
//   id_valid      out  1   IF/ID holds a valid instruction
//   id_instr      out 32   IF/ID instruction
//   id_pc         out 30   IF/ID PC+1 (word address after the instruction)
// -----------------------------------------------------------------------------
module if_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  input  logic        redirect,
  input  logic [29:0] redirect_npc,
  output logic        imem_req,
  output logic [29:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic        id_valid,
  output logic [31:0] id_instr,
  output logic [29:0] id_pc
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_FETCH = 2'd1;
  localparam logic [1:0] S_KILL  = 2'd2;

  localparam logic [29:0] RESET_WA = RESET_PC[31:2];

  logic [1:0]  r_state;
  logic [29:0] r_pc;
  logic [29:0] r_kill_addr;
  logic        r_skid_valid;
  logic [31:0] r_skid_instr;
  logic [29:0] r_skid_pc;
  logic        r_id_valid;
  logic [31:0] r_id_instr;
  logic [29:0] r_id_pc;

  logic        w_redir;
  logic        w_adv;
  logic        w_accept;
  logic [29:0] w_pc_inc;

  // A redirect seen while stalled is dropped; ID re-asserts it once released.
  assign w_redir  = redirect & ~stall;
  assign w_adv    = ~r_id_valid | ~stall;
  assign w_accept = (r_state == S_FETCH) & imem_req & imem_ready;
  assign w_pc_inc = r_pc + 30'd1;

  always_comb begin
    imem_req  = 1'b0;
    imem_addr = r_pc;
    case (r_state)
      S_FETCH: imem_req = ~r_skid_valid;
      S_KILL: begin
        imem_req  = 1'b1;
        imem_addr = r_kill_addr;
      end
      default: imem_req = 1'b0;
    endcase
  end

  assign id_valid = r_id_valid;
  assign id_instr = r_id_instr;
  assign id_pc    = r_id_pc;

  // FSM. Only a redirect that catches a request still waiting on the bus
  // needs KILL; one completing in the same cycle is simply not accepted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_kill_addr <= '0;
    end else begin
      case (r_state)
        S_IDLE: r_state <= S_FETCH;
        S_FETCH: begin
          if (w_redir & imem_req & ~imem_ready) begin
            r_state     <= S_KILL;
            r_kill_addr <= r_pc;
          end
        end
        S_KILL: begin
          if (imem_ready) r_state <= S_FETCH;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pc <= RESET_WA;
    end else if (w_redir) begin
      r_pc <= redirect_npc;
    end else if (w_accept) begin
      r_pc <= w_pc_inc;
    end
  end

  // IF/ID and skid. Redirect implies ~stall, hence adv, so the ~adv branch
  // never has to consider a squash. An accept cannot coincide with a full
  // skid because the request is withheld while the skid holds a word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_id_valid   <= 1'b0;
      r_id_instr   <= '0;
      r_id_pc      <= RESET_WA;
      r_skid_valid <= 1'b0;
      r_skid_instr <= '0;
      r_skid_pc    <= '0;
    end else if (w_adv) begin
      if (w_redir) begin
        r_id_valid   <= 1'b0;
        r_skid_valid <= 1'b0;
      end else if (r_skid_valid) begin
        r_id_valid   <= 1'b1;
        r_id_instr   <= r_skid_instr;
        r_id_pc      <= r_skid_pc;
        r_skid_valid <= 1'b0;
      end else if (w_accept) begin
        r_id_valid <= 1'b1;
        r_id_instr <= imem_rdata;
        r_id_pc    <= w_pc_inc;
      end else begin
        r_id_valid <= 1'b0;
      end
    end else if (w_accept) begin
      r_skid_valid <= 1'b1;
      r_skid_instr <= imem_rdata;
      r_skid_pc    <= w_pc_inc;
    end
  end

endmodule

// File: tb/tb_if_fetch_unit.sv
// -----------------------------------------------------------------------------
// tb_if_fetch_unit
//   Bench for if_fetch_unit. Memory contents are a pure function of the word
//   address. The reference model tracks only the architectural instruction
//   stream: every instruction ID consumes must be the next one in program
//   order, restarting at the redirect target whenever ID redirects.
// -----------------------------------------------------------------------------
module tb_if_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall;
  logic        redirect;
  logic [29:0] redirect_npc;
  logic        imem_req;
  logic [29:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;
  logic        id_valid;
  logic [31:0] id_instr;
  logic [29:0] id_pc;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  logic [31:0] salt;
  logic [29:0] exp_pc;
  logic        prev_pending;
  logic [29:0] prev_addr;
  logic        prev_hold;
  logic [29:0] prev_pc;
  logic [31:0] prev_instr;
  int unsigned idle_cnt;

  logic [29:0] saved_addr;
  logic [29:0] saved_pc;
  logic [31:0] rnd;

  if_fetch_unit #(.RESET_PC(32'h0000_3000)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .stall        (stall),
    .redirect     (redirect),
    .redirect_npc (redirect_npc),
    .imem_req     (imem_req),
    .imem_addr    (imem_addr),
    .imem_ready   (imem_ready),
    .imem_rdata   (imem_rdata),
    .id_valid     (id_valid),
    .id_instr     (id_instr),
    .id_pc        (id_pc)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [29:0] a);
    return {2'b00, a} ^ salt;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    exp_pc       = 30'h0000_0C00;
    prev_pending = 1'b0;
    prev_hold    = 1'b0;
    idle_cnt     = 0;
  endtask

  // Called at a negedge once the inputs for the coming posedge are set.
  task automatic tick();
    logic [29:0] nxt;
    imem_rdata = imem_ready ? mem_word(imem_addr) : $urandom;
    if (prev_pending) begin
      chk("bus_req_hold", {31'b0, imem_req}, 32'd1);
      chk("bus_addr_hold", {2'b0, imem_addr}, {2'b0, prev_addr});
    end
    if (prev_hold) begin
      chk("hold_valid", {31'b0, id_valid}, 32'd1);
      chk("hold_pc", {2'b0, id_pc}, {2'b0, prev_pc});
      chk("hold_instr", id_instr, prev_instr);
    end
    if (id_valid && !stall) begin
      nxt = exp_pc + 30'd1;
      chk("stream_pc", {2'b0, id_pc}, {2'b0, nxt});
      chk("stream_instr", id_instr, mem_word(exp_pc));
      exp_pc   = nxt;
      idle_cnt = 0;
    end else begin
      idle_cnt++;
      if (idle_cnt > 200) begin
        chk("liveness_gap", idle_cnt, 32'd200);
        idle_cnt = 0;
      end
    end
    if (redirect && !stall) exp_pc = redirect_npc;
    prev_pending = imem_req & ~imem_ready;
    prev_addr    = imem_addr;
    prev_hold    = id_valid & stall;
    prev_pc      = id_pc;
    prev_instr   = id_instr;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drive(input logic s, input logic r, input logic [29:0] npc, input logic rdy);
    stall        = s;
    redirect     = r;
    redirect_npc = npc;
    imem_ready   = rdy;
  endtask

  initial begin
    rst_n      = 1'b0;
    salt       = 32'h0;
    imem_rdata = 32'h0;
    drive(1'b0, 1'b0, 30'h0, 1'b0);
    model_reset();
    repeat (2) @(negedge clk);

    // Reset values
    chk("rst_id_valid", {31'b0, id_valid}, 32'd0);
    chk("rst_id_instr", id_instr, 32'd0);
    chk("rst_id_pc", {2'b0, id_pc}, 32'h0000_0C00);
    chk("rst_imem_req", {31'b0, imem_req}, 32'd0);

    // Streaming from RESET_PC with mem[i]=i
    rst_n = 1'b1;
    drive(1'b0, 1'b0, 30'h0, 1'b1);
    chk("idle_no_req", {31'b0, imem_req}, 32'd0);
    tick();
    chk("first_req", {31'b0, imem_req}, 32'd1);
    chk("first_addr", {2'b0, imem_addr}, 32'h0000_0C00);
    tick();
    for (int i = 0; i < 4; i++) begin
      chk("t1_valid", {31'b0, id_valid}, 32'd1);
      chk("t1_pc", {2'b0, id_pc}, 32'h0000_0C01 + 32'(i));
      chk("t1_instr", id_instr, 32'h0000_0C00 + 32'(i));
      chk("t1_addr", {2'b0, imem_addr}, 32'h0000_0C01 + 32'(i));
      tick();
    end

    // Three-cycle stall: one word goes to the skid and the request drops
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 1'b0, 30'h0, 1'b1);
      tick();
      chk("stall_req_drop", {31'b0, imem_req}, 32'd0);
    end
    drive(1'b0, 1'b0, 30'h0, 1'b1);
    repeat (3) tick();

    // Redirect with the request waiting: KILL drains the old address
    saved_addr = imem_addr;
    drive(1'b0, 1'b1, 30'h0000_0D00, 1'b0);
    tick();
    drive(1'b0, 1'b0, 30'h0, 1'b0);
    chk("kill_req", {31'b0, imem_req}, 32'd1);
    chk("kill_addr", {2'b0, imem_addr}, {2'b0, saved_addr});
    chk("kill_no_valid", {31'b0, id_valid}, 32'd0);
    tick();
    imem_ready = 1'b1;
    chk("kill_addr2", {2'b0, imem_addr}, {2'b0, saved_addr});
    chk("kill_no_valid2", {31'b0, id_valid}, 32'd0);
    tick();
    chk("redir_addr", {2'b0, imem_addr}, 32'h0000_0D00);
    chk("redir_req", {31'b0, imem_req}, 32'd1);
    chk("redir_no_valid", {31'b0, id_valid}, 32'd0);
    tick();
    chk("redir_valid", {31'b0, id_valid}, 32'd1);
    chk("redir_pc", {2'b0, id_pc}, 32'h0000_0D01);
    repeat (3) tick();

    // Redirect under stall is ignored; then redirect clears a full skid
    saved_pc = id_pc;
    drive(1'b1, 1'b1, 30'h0000_0123, 1'b1);
    tick();
    chk("stall_redir_ign", {2'b0, id_pc}, {2'b0, saved_pc});
    chk("skid_full_req", {31'b0, imem_req}, 32'd0);
    drive(1'b0, 1'b1, 30'h0000_0D00, 1'b1);
    tick();
    drive(1'b0, 1'b0, 30'h0, 1'b1);
    chk("skid_clr_valid", {31'b0, id_valid}, 32'd0);
    chk("skid_clr_addr", {2'b0, imem_addr}, 32'h0000_0D00);
    tick();
    chk("skid_clr_pc", {2'b0, id_pc}, 32'h0000_0D01);
    repeat (2) tick();

    // 30-bit PC wrap
    drive(1'b0, 1'b1, 30'h3FFF_FFFF, 1'b1);
    tick();
    drive(1'b0, 1'b0, 30'h0, 1'b1);
    chk("wrap_addr_top", {2'b0, imem_addr}, 32'h3FFF_FFFF);
    tick();
    chk("wrap_id_pc", {2'b0, id_pc}, 32'd0);
    chk("wrap_instr", id_instr, 32'h3FFF_FFFF);
    chk("wrap_next_addr", {2'b0, imem_addr}, 32'd0);
    repeat (2) tick();

    // Asynchronous reset with the skid full
    drive(1'b1, 1'b0, 30'h0, 1'b1);
    tick();
    chk("pre_rst_skid", {31'b0, imem_req}, 32'd0);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_id_valid", {31'b0, id_valid}, 32'd0);
    chk("arst_id_instr", id_instr, 32'd0);
    chk("arst_id_pc", {2'b0, id_pc}, 32'h0000_0C00);
    chk("arst_req", {31'b0, imem_req}, 32'd0);
    repeat (2) @(negedge clk);
    salt = 32'hA5C3_5A3C;
    model_reset();
    drive(1'b0, 1'b0, 30'h0, 1'b1);
    imem_rdata = 32'hDEAD_BEEF;
    rst_n = 1'b1;
    chk("rerst_idle", {31'b0, imem_req}, 32'd0);
    tick();
    chk("rerst_addr", {2'b0, imem_addr}, 32'h0000_0C00);
    tick();
    chk("rerst_pc", {2'b0, id_pc}, 32'h0000_0C01);

    // Randomized traffic against the stream model
    for (int i = 0; i < 3000; i++) begin
      rnd = $urandom;
      stall      = ($urandom_range(0, 3) == 0);
      redirect   = ($urandom_range(0, 9) == 0);
      imem_ready = ($urandom_range(0, 9) < 6);
      if ($urandom_range(0, 7) == 0)
        redirect_npc = 30'h3FFF_FFFC + 30'($urandom_range(0, 3));
      else
        redirect_npc = rnd[29:0];
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
